// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: load-use stall,
// taken-branch flush, registered EX operand forwarding selects, event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int ZR_IDX = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_aa,
  input  logic [4:0]       id_ab,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0] ZR = 5'(ZR_IDX);

  // The WB stage keeps no record: the register file writes before it reads,
  // so nothing downstream of MEM ever needs a forwarding select.
  logic       ex_valid, ex_rw, ex_mr;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_rw;
  logic [4:0] mem_rd;

  logic       m_ex_a, m_ex_b, m_mem_a, m_mem_b;
  logic       lu;
  logic [1:0] next_fwd_a, next_fwd_b;

  function automatic logic rec_match(input logic v, input logic rw,
                                     input logic [4:0] rd, input logic [4:0] addr);
    return v & rw & (rd == addr) & (addr != ZR);
  endfunction

  always_comb begin
    m_ex_a  = rec_match(ex_valid, ex_rw, ex_rd, id_aa);
    m_ex_b  = rec_match(ex_valid, ex_rw, ex_rd, id_ab);
    m_mem_a = rec_match(mem_valid, mem_rw, mem_rd, id_aa);
    m_mem_b = rec_match(mem_valid, mem_rw, mem_rd, id_ab);

    lu = id_valid & ex_mr & ((id_use_a & m_ex_a) | (id_use_b & m_ex_b));

    stall      = ~reset & lu & ~ex_br_taken;
    flush_ifid = ~reset & ex_br_taken;
    bubble_ex  = ~reset & (lu | ex_br_taken);

    // A load in EX never forwards from EX; after its bubble it sits in MEM.
    next_fwd_a = 2'b00;
    if (id_use_a) begin
      if (m_ex_a & ~ex_mr) next_fwd_a = 2'b01;
      else if (m_mem_a)    next_fwd_a = 2'b10;
    end
    next_fwd_b = 2'b00;
    if (id_use_b) begin
      if (m_ex_b & ~ex_mr) next_fwd_b = 2'b01;
      else if (m_mem_b)    next_fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_rd     <= 5'd0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_rd    <= 5'd0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_rw    <= ex_rw;
      mem_rd    <= ex_rd;
      if (bubble_ex) begin
        ex_valid <= 1'b0;
        ex_rw    <= 1'b0;
        ex_mr    <= 1'b0;
        ex_rd    <= 5'd0;
        fwd_a    <= 2'b00;
        fwd_b    <= 2'b00;
      end else begin
        ex_valid <= id_valid;
        ex_rw    <= id_regwrite;
        ex_mr    <= id_memread;
        ex_rd    <= id_rd;
        fwd_a    <= next_fwd_a;
        fwd_b    <= next_fwd_b;
      end
      if (stall && stall_cnt != '1)      stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ifid && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan sequences followed by random
// instruction streams, all checked against an in-flight instruction list model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_a, id_use_b, id_regwrite, id_memread, ex_br_taken;
  logic [4:0]  id_aa, id_ab, id_rd;
  logic        stall, flush_ifid, bubble_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;
  logic        stall4, flush4, bubble4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_aa(id_aa), .id_ab(id_ab),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_br_taken(ex_br_taken),
    .stall(stall), .flush_ifid(flush_ifid), .bubble_ex(bubble_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_aa(id_aa), .id_ab(id_ab),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_br_taken(ex_br_taken),
    .stall(stall4), .flush_ifid(flush4), .bubble_ex(bubble4),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // In-flight instructions past ID: slot 0 is in EX, slot 1 is in MEM.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } inst_t;

  inst_t       flight[2];
  bit   [1:0]  m_fwd_a, m_fwd_b;
  longint      m_stall_n, m_flush_n, m_flush4_n;
  int          tests = 0;
  int          fails = 0;
  int          stall_run = 0;

  function automatic bit writes(input inst_t i, input bit [4:0] addr);
    return i.v && i.rw && i.rd == addr && addr != 5'd31;
  endfunction

  // Youngest in-flight producer supplies the operand; a load still in EX
  // cannot supply anything, so the search moves on to older instructions.
  function automatic bit [1:0] pick_src(input bit [4:0] addr, input bit use_it);
    if (!use_it) return 2'b00;
    for (int s = 0; s < 2; s++) begin
      if (writes(flight[s], addr)) begin
        if (s == 0 && flight[s].mr) continue;
        return (s == 0) ? 2'b01 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    flight[0] = '{0, 0, 0, 0};
    flight[1] = '{0, 0, 0, 0};
    m_fwd_a = 0; m_fwd_b = 0;
    m_stall_n = 0; m_flush_n = 0; m_flush4_n = 0;
  endtask

  // One pipeline cycle: drive ID, check outputs against the model, advance it.
  task automatic step(input bit v, input bit [4:0] aa, input bit [4:0] ab,
                      input bit ua, input bit ub, input bit [4:0] rd,
                      input bit rw, input bit mr, input bit br, input bit rst);
    bit lu, e_stall, e_bub;
    inst_t load_ex;
    @(negedge clk);
    id_valid = v; id_aa = aa; id_ab = ab; id_use_a = ua; id_use_b = ub;
    id_rd = rd; id_regwrite = rw; id_memread = mr; ex_br_taken = br; reset = rst;
    #1;
    load_ex = flight[0];
    lu = v && load_ex.mr && ((ua && writes(load_ex, aa)) || (ub && writes(load_ex, ab)));
    e_stall = lu && !br;
    e_bub = lu || br;
    chk("fwd_a", fwd_a, m_fwd_a);
    chk("fwd_b", fwd_b, m_fwd_b);
    chk("stall_cnt", stall_cnt, m_stall_n);
    chk("flush_cnt", flush_cnt, m_flush_n);
    chk("flush_cnt4", flush_cnt4, m_flush4_n);
    if (!rst) begin
      chk("stall", stall, e_stall);
      chk("flush_ifid", flush_ifid, br);
      chk("bubble_ex", bubble_ex, e_bub);
      stall_run = stall ? stall_run + 1 : 0;
      chk("stall_run_le_1", stall_run <= 1, 1);
    end
    if (rst) begin
      model_reset();
      stall_run = 0;
    end else begin
      if (e_stall) m_stall_n = (m_stall_n == 64'hFFFF_FFFF) ? m_stall_n : m_stall_n + 1;
      if (br) begin
        m_flush_n  = (m_flush_n == 64'hFFFF_FFFF) ? m_flush_n : m_flush_n + 1;
        m_flush4_n = (m_flush4_n == 15) ? m_flush4_n : m_flush4_n + 1;
      end
      m_fwd_a = e_bub ? 2'b00 : pick_src(aa, ua);
      m_fwd_b = e_bub ? 2'b00 : pick_src(ab, ub);
      flight[1] = flight[0];
      flight[0] = e_bub ? inst_t'{0, 0, 0, 0} : inst_t'{v, rd, rw && v, mr && v};
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    longint saved;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    chk("reset_stall", stall, 0);
    chk("reset_fwd_a", fwd_a, 0);

    // ADD X1,X2,X3 ; SUB X4,X1,X5
    step(1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 5, 1, 1, 4, 1, 0, 0, 0);
    nop();
    chk("ex_ex_fwd_a", fwd_a, 2'b01);
    chk("ex_ex_fwd_b", fwd_b, 2'b00);

    // ADD X1 ; NOP ; ORR X6,X7,X1
    step(1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    nop();
    step(1, 7, 1, 1, 1, 6, 1, 0, 0, 0);
    nop();
    chk("mem_ex_fwd_b", fwd_b, 2'b10);

    // ADD X1 ; ADD X1 ; consumer of X1 -> youngest wins
    step(1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    step(1, 4, 5, 1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 8, 1, 0, 0, 0);
    nop();
    chk("youngest_fwd_a", fwd_a, 2'b01);

    // LDUR X2 ; ADD X3,X2,X2 (held one cycle)
    saved = m_stall_n;
    step(1, 0, 0, 1, 0, 2, 1, 1, 0, 0);
    step(1, 2, 2, 1, 1, 3, 1, 0, 0, 0);
    step(1, 2, 2, 1, 1, 3, 1, 0, 0, 0);
    nop();
    chk("lu_fwd_a", fwd_a, 2'b10);
    chk("lu_fwd_b", fwd_b, 2'b10);
    chk("lu_stall_cnt", stall_cnt, saved + 1);

    // XZR never forwards nor stalls, even after a load
    step(1, 0, 0, 1, 0, 31, 1, 1, 0, 0);
    step(1, 31, 31, 1, 1, 9, 1, 0, 0, 0);
    nop();
    chk("xzr_fwd_a", fwd_a, 2'b00);

    // Branch taken while a load-use hazard is pending
    saved = m_stall_n;
    step(1, 0, 0, 1, 0, 2, 1, 1, 0, 0);
    step(1, 2, 2, 1, 1, 3, 1, 0, 1, 0);
    step(1, 2, 2, 1, 1, 3, 1, 0, 0, 0);
    chk("br_lu_stall_cnt", stall_cnt, saved);

    // Reset during a stall cycle
    step(1, 0, 0, 1, 0, 2, 1, 1, 0, 0);
    step(1, 2, 2, 1, 1, 3, 1, 0, 0, 1);
    nop();
    chk("rst_mid_stall", {stall, flush_ifid, bubble_ex, fwd_a, fwd_b}, 0);
    chk("rst_mid_stall_cnt", stall_cnt, 0);

    // 20 flushes saturate the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop();
    chk("sat_flush_cnt4", flush_cnt4, 15);
    chk("sat_flush_cnt", flush_cnt, 20);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 5) != 0,
           5'($urandom_range(0, 4) == 4 ? 31 : $urandom_range(0, 3)),
           5'($urandom_range(0, 4) == 4 ? 31 : $urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 4) == 4 ? 31 : $urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 150) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
